// File: rtl/burst_memory.sv
// Word-organised synchronous RAM responder mapped at start_addr.
// Serves single-word and fixed-length (4/8/16) burst reads and writes.
module burst_memory #(
    parameter int unsigned data_width    = 32,
    parameter int unsigned address_width = 32,
    parameter int unsigned depth         = 1048576,
    parameter logic [address_width-1:0] start_addr = 32'h80020000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [address_width-1:0] address,
    input  logic [data_width-1:0]    data_in,
    input  logic [1:0]               access_size,
    input  logic                     rw,
    input  logic                     enable,
    output logic                     busy,
    output logic [data_width-1:0]    data_out
);

    localparam int unsigned words = depth / 4;
    localparam int unsigned idx_w = $clog2(words);
    localparam logic [address_width-1:0] depth_a = address_width'(depth);
    localparam logic [address_width-1:0] step    = address_width'(4);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                     state, next_state;
    logic [3:0]                 beat_cnt, last_beat, req_last;
    logic [address_width-1:0]   cur_addr, beat_addr, offset;
    logic                       rw_q, beat_rw, beat_valid, in_range, wr_en;
    logic [idx_w-1:0]           idx;
    logic [data_width-1:0]      mem [0:words-1];

    always_comb begin
        case (access_size)
            2'b00:   req_last = 4'd0;
            2'b01:   req_last = 4'd3;
            2'b10:   req_last = 4'd7;
            default: req_last = 4'd15;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Beat 0 is served straight from the live request inputs; later beats use the captured copy.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        beat_valid = 1'b0;
        beat_addr  = cur_addr;
        beat_rw    = rw_q;
        case (state)
            IDLE: begin
                beat_addr = address;
                beat_rw   = rw;
                if (enable) begin
                    beat_valid = 1'b1;
                    if (req_last != 4'd0) next_state = BURST;
                end
            end
            BURST: begin
                busy       = 1'b1;
                beat_valid = 1'b1;
                if (beat_cnt == last_beat) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // A wrapped address lands below start_addr and so fails the first term.
    assign offset   = beat_addr - start_addr;
    assign in_range = (beat_addr >= start_addr) && (offset < depth_a);
    assign idx      = offset[idx_w+1:2];
    assign wr_en    = beat_valid && !beat_rw && in_range && reset_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt  <= '0;
            last_beat <= '0;
            cur_addr  <= '0;
            rw_q      <= 1'b0;
            data_out  <= '0;
        end else begin
            if (state == IDLE && enable) begin
                beat_cnt  <= (req_last != 4'd0) ? 4'd1 : 4'd0;
                last_beat <= req_last;
                cur_addr  <= address + step;
                rw_q      <= rw;
            end else if (state == BURST) begin
                beat_cnt <= (beat_cnt == last_beat) ? 4'd0 : beat_cnt + 4'd1;
                cur_addr <= cur_addr + step;
            end
            if (beat_valid && beat_rw)
                data_out <= in_range ? mem[idx] : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[idx] <= data_in;
    end

endmodule

// File: tb/tb_burst_memory.sv
// Directed self-checking bench for burst_memory.
module tb_burst_memory;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  access_size;
    logic        rw;
    logic        enable;
    logic        busy;
    logic [31:0] data_out;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] base = 32'h80020000;

    burst_memory #(
        .data_width(32),
        .address_width(32),
        .depth(1048576),
        .start_addr(32'h80020000)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .address(address),
        .data_in(data_in),
        .access_size(access_size),
        .rw(rw),
        .enable(enable),
        .busy(busy),
        .data_out(data_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // drive inputs on the falling edge, then sample 1 ns after the rising edge
    task automatic beat(input logic en, input logic r, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] d);
        @(negedge clock);
        enable = en; rw = r; address = a; access_size = sz; data_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [1:0] sz, input int unsigned len,
                               input logic [31:0] d0, input string tag);
        for (int unsigned k = 0; k < len; k++) begin
            beat(k == 0, 1'b0, a, sz, d0 + k);
            check({tag, "_busy"}, {31'd0, busy}, {31'd0, k < len - 1});
        end
        enable = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; rw = 1'b0; address = '0; data_in = '0; access_size = 2'b00;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_data_out", data_out, 32'd0);
        @(negedge clock); reset_n = 1'b1;

        // single-word write then read
        beat(1'b1, 1'b0, base, 2'b00, 32'hDEADBEEF);
        check("t1_wr_busy", {31'd0, busy}, 32'd0);
        beat(1'b1, 1'b1, base, 2'b00, 32'h0);
        check("t1_rd_data", data_out, 32'hDEADBEEF);
        check("t1_rd_busy", {31'd0, busy}, 32'd0);
        enable = 1'b0;

        // 4-word write burst then 4-word read burst
        write_burst(base + 32'h10, 2'b01, 4, 32'd1, "t2_wr");
        for (int unsigned k = 0; k < 4; k++) begin
            beat(k == 0, 1'b1, base + 32'h10, 2'b01, 32'h0);
            check("t2_rd_data", data_out, k + 1);
            check("t2_rd_busy", {31'd0, busy}, {31'd0, k < 3});
        end
        enable = 1'b0;

        // back-to-back: read issued at first edge with busy low
        write_burst(base + 32'h100, 2'b01, 4, 32'hA0, "t6_wr");
        for (int unsigned k = 0; k < 4; k++) begin
            beat(k == 0, 1'b1, base + 32'h100, 2'b01, 32'h0);
            check("t6_rd_data", data_out, 32'hA0 + k);
        end
        enable = 1'b0;

        // 16-word read with a stray request during beat 5
        write_burst(base + 32'h200, 2'b11, 16, 32'h100, "t3_wr");
        for (int unsigned k = 0; k < 16; k++) begin
            if (k == 5) beat(1'b1, 1'b0, base + 32'h10, 2'b00, 32'h5555);
            else        beat(k == 0, 1'b1, base + 32'h200, 2'b11, 32'h0);
            check("t3_rd_data", data_out, 32'h100 + k);
            check("t3_rd_busy", {31'd0, busy}, {31'd0, k < 15});
        end
        enable = 1'b0;
        beat(1'b1, 1'b1, base + 32'h10, 2'b00, 32'h0);
        check("t3_ignored_write", data_out, 32'd1);

        // out-of-range accesses; last word and word 0 must not be aliased
        beat(1'b1, 1'b0, base + 32'hFFFF8, 2'b00, 32'h76);
        beat(1'b1, 1'b0, base + 32'hFFFFC, 2'b00, 32'h77);
        beat(1'b1, 1'b0, 32'h7FFFFFFC, 2'b00, 32'h55);
        beat(1'b1, 1'b0, base + 32'h100000, 2'b00, 32'h66);
        beat(1'b1, 1'b1, base, 2'b00, 32'h0);
        check("t4_word0_kept", data_out, 32'hDEADBEEF);
        beat(1'b1, 1'b1, 32'h7FFFFFFC, 2'b00, 32'h0);
        check("t4_rd_below", data_out, 32'h0);
        beat(1'b1, 1'b1, base + 32'h100000, 2'b00, 32'h0);
        check("t4_rd_above", data_out, 32'h0);
        // burst crossing the top of memory
        for (int unsigned k = 0; k < 4; k++) begin
            logic [31:0] exp_v [4];
            exp_v = '{32'h76, 32'h77, 32'h0, 32'h0};
            beat(k == 0, 1'b1, base + 32'hFFFF8, 2'b01, 32'h0);
            check("t4_cross_data", data_out, exp_v[k]);
            check("t4_cross_busy", {31'd0, busy}, {31'd0, k < 3});
        end
        enable = 1'b0;

        // reset in the middle of an 8-word write
        write_burst(base + 32'h400, 2'b10, 8, 32'hF0, "t5_pre");
        beat(1'b1, 1'b1, base, 2'b00, 32'h0);
        check("t5_pre_data", data_out, 32'hDEADBEEF);
        for (int unsigned k = 0; k < 4; k++)
            beat(k == 0, 1'b0, base + 32'h400, 2'b10, 32'hE0 + k);
        enable = 1'b0;
        check("t5_busy_mid", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_data", data_out, 32'd0);
        @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            beat(k == 0, 1'b1, base + 32'h400, 2'b10, 32'h0);
            check("t5_rd_data", data_out, (k < 4) ? 32'hE0 + k : 32'hF0 + k);
        end
        enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
